ex_mem: RTL and testbench
=========================

Name: ex_mem

Overview:
- Elastic pipeline register between the execute stage and the memory stage.
- Captures the execute stage's write-back triple (addr, enable, data) under a valid/ready handshake.
- A 2-entry skid buffer lets the downstream ready break timing without dropping or duplicating results.
- Supports synchronous flush for branch/exception squash.

Parameters:
- DATA_WIDTH, 32, width of the write-back data (matches the register data bus).
- ADDR_WIDTH, 5, width of the register write address (matches the register address bus).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  execute stage presents a result.
- in_ready  output  1  buffer accepts the result this cycle.
- in_write_addr  input  ADDR_WIDTH  destination register from execute.
- in_write_enable  input  1  register-write request from execute.
- in_write_data  input  DATA_WIDTH  result from execute.
- out_valid  output  1  entry presented to the memory stage.
- out_ready  input  1  memory stage consumes the entry this cycle.
- out_write_addr  output  ADDR_WIDTH  head entry address.
- out_write_enable  output  1  head entry write enable, gated by out_valid.
- out_write_data  output  DATA_WIDTH  head entry data.

Behaviour:
- Storage: a main register (head, drives outputs) and a skid register. All outputs come straight from flops.
- State machine: EMPTY (no entries), ONE (main holds an entry), TWO (main and skid both hold entries).
- in_ready = (state != TWO), decoded from state only. No combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY).
- Handshake: a transfer occurs when valid && ready on the same rising edge. The producer must hold its payload stable while in_valid=1 and in_ready=0.

Transitions (flush=0):
- EMPTY, in_valid=1: main <= input; go to ONE.
- EMPTY, in_valid=0: stay EMPTY.
- ONE, out_ready=1, in_valid=1: main <= input; stay ONE (full throughput, 1 result per cycle).
- ONE, out_ready=1, in_valid=0: go to EMPTY.
- ONE, out_ready=0, in_valid=1: skid <= input; go to TWO.
- ONE, out_ready=0, in_valid=0: hold.
- TWO, out_ready=1: main <= skid; go to ONE. Input is ignored because in_ready=0.
- TWO, out_ready=0: hold both entries.

Timing and ordering:
- Latency: an input accepted at edge N appears on the outputs after edge N, provided the head slot is free.
- Ordering is strictly FIFO; no entry is ever lost or duplicated.

Flush:
- flush=1 at an edge sends the state to EMPTY and overrides every transition.
- Inputs presented in that cycle are discarded, even if in_ready was 1.
- out_write_enable drops to 0 the following cycle.

Reset and output values:
- reset=0 immediately gives state EMPTY, main/skid payload 0, out_valid=0, out_write_enable=0, out_write_addr=0, out_write_data=0, in_ready=1.
- Reset asserted mid-transfer discards all entries. The first accept after release lands in main.
- When out_valid=0, out_write_enable is forced 0. Address and data hold their last value; verification must not check them while invalid.

Width rules:
- Payload is passed bit-exact with no arithmetic.
- in_write_enable=0 entries still occupy a slot and flow through (bubbles carrying no write).

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- When defined, two extra outputs are added:
  - stall_count (16 bits): increments each cycle with out_valid=1 and out_ready=0.
  - backpressure_count (16 bits): increments each cycle with in_valid=1 and in_ready=0.
- Both counters saturate at 16'hFFFF, clear on reset, and clear on flush.
- When undefined, neither the ports nor the logic exist; behaviour is otherwise identical.

Decomposition:
- Shared package/utility header holds:
  - data/address bus widths;
  - state encodings EX_MEM_EMPTY=2'd0, EX_MEM_ONE=2'd1, EX_MEM_TWO=2'd2;
  - the zero-word constant used for reset payloads.
- One natural sub-module, pipe_slot: a single payload register with load enable and asynchronous clear, instantiated twice (main, skid).

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 4 cycles with data 0x1,0x2,0x3,0x4, addr 1..4 -> outputs 0x1..0x4 on consecutive cycles one cycle later; in_ready stays 1.
- Backpressure: send 0xA then 0xB with out_ready=0 -> state TWO, in_ready=0, out_write_data=0xA. Raise out_ready for 2 cycles -> 0xA then 0xB, then out_valid=0.
- Stall hold: in TWO, drive in_valid=1 with data 0xC while in_ready=0 for 3 cycles -> 0xC not accepted until in_ready=1. Final order is 0xA,0xB,0xC.
- Flush: in TWO, pulse flush with in_valid=1 and data 0xD -> next cycle out_valid=0, in_ready=1, out_write_enable=0; 0xD never appears.
- Async reset: in ONE holding 0x55, drive reset=0 mid-cycle -> outputs zero immediately without waiting for a clock edge. After release, in_ready=1 and the first input 0x77 emerges next cycle.
- With EX_MEM_STATS_EN defined: hold out_ready=0 with 1 entry for 5 cycles -> stall_count=5. Flush -> stall_count=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared widths, state encoding and constants for the ex_mem pipeline register.
package ex_mem_pkg;

  localparam int unsigned EX_MEM_DATA_W = 32;
  localparam int unsigned EX_MEM_ADDR_W = 5;
  localparam int unsigned EX_MEM_CNT_W  = 16;

  localparam logic [EX_MEM_DATA_W-1:0] EX_MEM_ZERO_WORD = '0;

  typedef enum logic [1:0] {
    EX_MEM_EMPTY = 2'd0,
    EX_MEM_ONE   = 2'd1,
    EX_MEM_TWO   = 2'd2
  } ex_mem_state_e;

  function automatic logic [EX_MEM_CNT_W-1:0] sat_inc(input logic [EX_MEM_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_slot.sv
// Single payload register with load enable and asynchronous active-low clear.
module pipe_slot #(
  parameter int unsigned      W         = 1,
  parameter logic [W-1:0]     RESET_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_mem.sv
// EX/MEM elastic pipeline register: 2-entry skid buffer with synchronous flush.
// Optional EX_MEM_STATS_EN adds saturating stall/backpressure counters.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = EX_MEM_DATA_W,
  parameter int unsigned ADDR_WIDTH = EX_MEM_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_write_addr,
  input  logic                  in_write_enable,
  input  logic [DATA_WIDTH-1:0] in_write_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_write_addr,
  output logic                  out_write_enable,
  output logic [DATA_WIDTH-1:0] out_write_data
`ifdef EX_MEM_STATS_EN
  ,
  output logic [EX_MEM_CNT_W-1:0] stall_count,
  output logic [EX_MEM_CNT_W-1:0] backpressure_count
`endif
);

  localparam int unsigned         SLOT_W     = ADDR_WIDTH + 1 + DATA_WIDTH;
  localparam logic [SLOT_W-1:0]   SLOT_RESET = SLOT_W'(EX_MEM_ZERO_WORD);

  ex_mem_state_e     r_state;
  ex_mem_state_e     w_state_nxt;
  logic              w_load_main;
  logic              w_load_skid;
  logic [SLOT_W-1:0] w_in_word;
  logic [SLOT_W-1:0] w_main_d;
  logic [SLOT_W-1:0] w_main_q;
  logic [SLOT_W-1:0] w_skid_q;
  logic              w_main_we;

  assign w_in_word = {in_write_addr, in_write_enable, in_write_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= EX_MEM_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush blocks every load as well as the state change, so squashed inputs never land.
  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_main_d    = w_in_word;
    if (flush) begin
      w_state_nxt = EX_MEM_EMPTY;
    end else begin
      unique case (r_state)
        EX_MEM_EMPTY: begin
          if (in_valid) begin
            w_load_main = 1'b1;
            w_state_nxt = EX_MEM_ONE;
          end
        end
        EX_MEM_ONE: begin
          if (out_ready && in_valid) begin
            w_load_main = 1'b1;
          end else if (out_ready) begin
            w_state_nxt = EX_MEM_EMPTY;
          end else if (in_valid) begin
            w_load_skid = 1'b1;
            w_state_nxt = EX_MEM_TWO;
          end
        end
        EX_MEM_TWO: begin
          if (out_ready) begin
            w_main_d    = w_skid_q;
            w_load_main = 1'b1;
            w_state_nxt = EX_MEM_ONE;
          end
        end
        default: w_state_nxt = EX_MEM_EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .W         (SLOT_W),
    .RESET_VAL (SLOT_RESET)
  ) u_main (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load_main),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  pipe_slot #(
    .W         (SLOT_W),
    .RESET_VAL (SLOT_RESET)
  ) u_skid (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load_skid),
    .i_d    (w_in_word),
    .o_q    (w_skid_q)
  );

  assign in_ready  = (r_state != EX_MEM_TWO);
  assign out_valid = (r_state != EX_MEM_EMPTY);
  assign {out_write_addr, w_main_we, out_write_data} = w_main_q;
  assign out_write_enable = w_main_we & out_valid;

`ifdef EX_MEM_STATS_EN
  logic [EX_MEM_CNT_W-1:0] r_stall_cnt;
  logic [EX_MEM_CNT_W-1:0] r_bp_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_bp_cnt    <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
      r_bp_cnt    <= '0;
    end else begin
      if (out_valid && !out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (in_valid && !in_ready)   r_bp_cnt    <= sat_inc(r_bp_cnt);
    end
  end

  assign stall_count        = r_stall_cnt;
  assign backpressure_count = r_bp_cnt;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed + randomized bench for ex_mem against a 2-deep FIFO queue model.
module tb_ex_mem;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_write_addr = '0;
  logic          in_write_enable = 1'b0;
  logic [DW-1:0] in_write_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_write_addr;
  logic          out_write_enable;
  logic [DW-1:0] out_write_data;
`ifdef EX_MEM_STATS_EN
  logic [15:0]   stall_count;
  logic [15:0]   backpressure_count;
`endif

  ex_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_write_addr    (in_write_addr),
    .in_write_enable  (in_write_enable),
    .in_write_data    (in_write_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_write_addr   (out_write_addr),
    .out_write_enable (out_write_enable),
    .out_write_data   (out_write_data)
`ifdef EX_MEM_STATS_EN
    ,
    .stall_count        (stall_count),
    .backpressure_count (backpressure_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_stall = '0;
  logic [15:0] m_bp    = '0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_we", out_write_enable, (mq.size() > 0) ? mq[0].we : 1'b0);
    if (mq.size() > 0) begin
      chk("out_addr", out_write_addr, mq[0].a);
      chk("out_data", out_write_data, mq[0].d);
    end
`ifdef EX_MEM_STATS_EN
    chk("stall_count", stall_count, m_stall);
    chk("bp_count", backpressure_count, m_bp);
`endif
  endtask

  // One clock: update the queue model from pre-edge conditions, then check post-edge.
  task automatic cycle();
    bit   valid_pre;
    bit   ready_pre;
    ent_t e;
    valid_pre = mq.size() > 0;
    ready_pre = mq.size() < 2;
    @(posedge clock);
    if (flush) begin
      mq.delete();
      m_stall = '0;
      m_bp    = '0;
    end else begin
      if (valid_pre && !out_ready && m_stall != 16'hFFFF) m_stall++;
      if (in_valid && !ready_pre && m_bp != 16'hFFFF) m_bp++;
      if (valid_pre && out_ready) void'(mq.pop_front());
      if (in_valid && ready_pre) begin
        e.a  = in_write_addr;
        e.we = in_write_enable;
        e.d  = in_write_data;
        mq.push_back(e);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] a, input bit we,
                       input logic [DW-1:0] d, input bit ordy, input bit fl);
    in_valid        = v;
    in_write_addr   = a;
    in_write_enable = we;
    in_write_data   = d;
    out_ready       = ordy;
    flush           = fl;
  endtask

  initial begin
    bit hold;
    // Reset values
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_we", out_write_enable, 1'b0);
    chk("rst_out_addr", out_write_addr, '0);
    chk("rst_out_data", out_write_data, '0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Streaming
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), 1'b1, DW'(i), 1'b1, 1'b0);
      cycle();
      chk("stream_data", out_write_data, DW'(i));
      chk("stream_ready", in_ready, 1'b1);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("stream_drain", out_valid, 1'b0);

    // Backpressure into TWO
    drive(1'b1, 5'd10, 1'b1, 32'hA, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 5'd11, 1'b0, 32'hB, 1'b0, 1'b0);
    cycle();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head", out_write_data, 32'hA);

    // Stall hold: 0xC offered while full
    drive(1'b1, 5'd12, 1'b1, 32'hC, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_head", out_write_data, 32'hA);
      chk("hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    cycle();
    chk("order_b", out_write_data, 32'hB);
    chk("order_b_we", out_write_enable, 1'b0);
    cycle();
    chk("order_c", out_write_data, 32'hC);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    chk("order_drain", out_valid, 1'b0);

    // Flush while TWO, with a live input
    drive(1'b1, 5'd1, 1'b1, 32'h11, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 5'd2, 1'b1, 32'h12, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 5'd3, 1'b1, 32'hD, 1'b0, 1'b1);
    cycle();
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    chk("flush_we", out_write_enable, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flush_no_d", out_valid, 1'b0);
    end

`ifdef EX_MEM_STATS_EN
    drive(1'b1, 5'd4, 1'b1, 32'h44, 1'b0, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    chk("stall5", stall_count, 16'd5);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("stall_flush", stall_count, 16'd0);
`endif

    // Asynchronous reset mid-cycle while holding 0x55
    drive(1'b1, 5'd5, 1'b1, 32'h55, 1'b0, 1'b0);
    cycle();
    chk("pre_rst_head", out_write_data, 32'h55);
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    mq.delete();
    m_stall = '0;
    m_bp    = '0;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_we", out_write_enable, 1'b0);
    chk("arst_addr", out_write_addr, '0);
    chk("arst_data", out_write_data, '0);
    chk("arst_ready", in_ready, 1'b1);
    #1;
    reset = 1'b1;
    drive(1'b1, 5'd7, 1'b1, 32'h77, 1'b1, 1'b0);
    cycle();
    chk("post_rst_data", out_write_data, 32'h77);
    chk("post_rst_valid", out_valid, 1'b1);

    // Randomized traffic; payload held stable while stalled
    for (int i = 0; i < 400; i++) begin
      hold = in_valid && (mq.size() >= 2);
      if (!hold) begin
        in_valid        = ($urandom_range(0, 9) < 7);
        in_write_addr   = AW'($urandom);
        in_write_enable = 1'($urandom);
        in_write_data   = $urandom;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
